// File: rtl/apb_uart_regs.sv
// APB3 register block for the UART: configuration registers, TX launch FSM and RX byte buffer.
// Optional feature macro: APB_UART_RX_FIFO_EN selects an RX_DEPTH-entry FIFO instead of a single holding register.
module apb_uart_regs #(
    parameter int          RX_DEPTH     = 4,
    parameter logic [31:0] RST_BAUD     = 32'd115200,
    parameter logic [31:0] RST_CLK_FREQ = 32'd50000000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [31:0] BAUD_RATE_TX,
    output logic [31:0] BAUD_RATE_RX,
    output logic [31:0] CLK_FREQ,
    output logic [3:0]  frame_size,
    output logic [1:0]  parity_type,
    output logic        bclk_en,
    output logic [7:0]  din,
    output logic        tx_en,
    input  logic        tx_done,
    input  logic        rx_done,
    input  logic        error,
    input  logic        BR_config_error,
    input  logic [7:0]  dout
);

    typedef enum logic {TX_IDLE = 1'b0, TX_BUSY = 1'b1} tx_state_t;

    localparam logic [5:0] IDX_CTRL   = 6'd0;
    localparam logic [5:0] IDX_BAUDTX = 6'd1;
    localparam logic [5:0] IDX_BAUDRX = 6'd2;
    localparam logic [5:0] IDX_CLK    = 6'd3;
    localparam logic [5:0] IDX_TXDATA = 6'd4;
    localparam logic [5:0] IDX_RXDATA = 6'd5;
    localparam logic [5:0] IDX_STATUS = 6'd6;

    tx_state_t   state_r, state_next_s;
    logic        bclk_en_r;
    logic [3:0]  frame_size_r;
    logic [1:0]  parity_type_r;
    logic [31:0] baud_tx_r, baud_rx_r, clk_freq_r;
    logic [7:0]  din_r;
    logic        tx_en_r;
    logic        tx_done_prev_r, rx_done_prev_r;
    logic        overrun_r, rx_err_r;

    logic        access_s, wr_s, rd_s;
    logic [5:0]  idx_s;
    logic        addr_unused_s;
    logic        tx_wr_s, tx_rise_s, w1c_s;
    logic        pop_req_s, pop_s, push_req_s, push_s;
    logic        rx_empty_s, rx_full_s;
    logic [7:0]  rx_head_s;
    logic [3:0]  rx_count4_s;
    logic [31:0] status_s;
    logic [31:0] prdata_s;
    logic        pslverr_s;

    assign access_s      = PSEL & PENABLE;
    assign wr_s          = access_s & PWRITE;
    assign rd_s          = access_s & ~PWRITE;
    assign idx_s         = PADDR[7:2];
    assign addr_unused_s = ^PADDR[1:0];

    assign tx_wr_s    = wr_s & (idx_s == IDX_TXDATA);
    assign tx_rise_s  = tx_done & ~tx_done_prev_r;
    assign w1c_s      = wr_s & (idx_s == IDX_STATUS);
    assign pop_req_s  = rd_s & (idx_s == IDX_RXDATA);
    assign pop_s      = pop_req_s & ~rx_empty_s;
    assign push_req_s = rx_done & ~rx_done_prev_r;
    // A full buffer still accepts a byte when a pop frees a slot in the same cycle.
    assign push_s     = push_req_s & (~rx_full_s | pop_s);

    // TX FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            TX_IDLE: begin
                if (tx_wr_s) begin
                    state_next_s = TX_BUSY;
                end else begin
                    state_next_s = TX_IDLE;
                end
            end
            TX_BUSY: begin
                if (tx_rise_s) begin
                    state_next_s = TX_IDLE;
                end else begin
                    state_next_s = TX_BUSY;
                end
            end
            default: state_next_s = TX_IDLE;
        endcase
    end

    // TX FSM state, launch byte and status edge detectors.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r        <= TX_IDLE;
            tx_en_r        <= 1'b0;
            din_r          <= 8'h00;
            tx_done_prev_r <= 1'b0;
            rx_done_prev_r <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            tx_en_r        <= (state_next_s == TX_BUSY);
            tx_done_prev_r <= tx_done;
            rx_done_prev_r <= rx_done;
            if (tx_wr_s && (state_r == TX_IDLE)) begin
                din_r <= PWDATA[7:0];
            end
        end
    end

    // Configuration registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bclk_en_r     <= 1'b0;
            frame_size_r  <= 4'd8;
            parity_type_r <= 2'b00;
            baud_tx_r     <= RST_BAUD;
            baud_rx_r     <= RST_BAUD;
            clk_freq_r    <= RST_CLK_FREQ;
        end else if (wr_s) begin
            case (idx_s)
                IDX_CTRL: begin
                    bclk_en_r     <= PWDATA[0];
                    frame_size_r  <= PWDATA[4:1];
                    parity_type_r <= PWDATA[6:5];
                end
                IDX_BAUDTX: baud_tx_r  <= PWDATA;
                IDX_BAUDRX: baud_rx_r  <= PWDATA;
                IDX_CLK:    clk_freq_r <= PWDATA;
                default:    bclk_en_r  <= bclk_en_r;
            endcase
        end
    end

    // Sticky flags; a new event in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overrun_r <= 1'b0;
            rx_err_r  <= 1'b0;
        end else begin
            overrun_r <= (overrun_r & ~(w1c_s & PWDATA[3])) | (push_req_s & ~push_s);
            rx_err_r  <= (rx_err_r & ~(w1c_s & PWDATA[4])) | (push_req_s & error);
        end
    end

`ifdef APB_UART_RX_FIFO_EN
    localparam int PW = $clog2(RX_DEPTH);
    localparam int CW = $clog2(RX_DEPTH + 1);

    logic [7:0]    mem_r [RX_DEPTH];
    logic [PW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0] count_r;

    assign rx_empty_s  = (count_r == {CW{1'b0}});
    assign rx_full_s   = (count_r == CW'(RX_DEPTH));
    assign rx_head_s   = mem_r[rd_ptr_r];
    assign rx_count4_s = 4'(count_r);

    // RX FIFO storage, power-of-two pointers wrap naturally.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < RX_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= dout;
                wr_ptr_r        <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end
`else
    localparam int rx_depth_unused = RX_DEPTH;

    logic [7:0] hold_r;
    logic       valid_r;

    assign rx_empty_s  = ~valid_r;
    assign rx_full_s   = valid_r;
    assign rx_head_s   = hold_r;
    assign rx_count4_s = {3'b000, valid_r};

    // Single-entry RX holding register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_r  <= 8'h00;
            valid_r <= 1'b0;
        end else if (push_s) begin
            hold_r  <= dout;
            valid_r <= 1'b1;
        end else if (pop_s) begin
            valid_r <= 1'b0;
        end
    end
`endif

    assign status_s = {20'd0, rx_count4_s, 2'b00, BR_config_error, rx_err_r, overrun_r,
                       rx_full_s, rx_empty_s, (state_r == TX_BUSY)};

    // APB read data and error decode for the access cycle.
    always_comb begin
        prdata_s  = 32'd0;
        pslverr_s = 1'b0;
        if (access_s) begin
            case (idx_s)
                IDX_CTRL:   prdata_s = PWRITE ? 32'd0 : {25'd0, parity_type_r, frame_size_r, bclk_en_r};
                IDX_BAUDTX: prdata_s = PWRITE ? 32'd0 : baud_tx_r;
                IDX_BAUDRX: prdata_s = PWRITE ? 32'd0 : baud_rx_r;
                IDX_CLK:    prdata_s = PWRITE ? 32'd0 : clk_freq_r;
                IDX_TXDATA: pslverr_s = PWRITE & (state_r == TX_BUSY);
                IDX_RXDATA: begin
                    if (PWRITE || rx_empty_s) begin
                        pslverr_s = 1'b1;
                    end else begin
                        prdata_s = {24'd0, rx_head_s};
                    end
                end
                IDX_STATUS: prdata_s = PWRITE ? 32'd0 : status_s;
                default:    pslverr_s = 1'b1;
            endcase
        end else begin
            prdata_s  = 32'd0;
            pslverr_s = 1'b0;
        end
    end

    assign PRDATA       = prdata_s;
    assign PSLVERR      = pslverr_s;
    assign PREADY       = 1'b1;
    assign BAUD_RATE_TX = baud_tx_r;
    assign BAUD_RATE_RX = baud_rx_r;
    assign CLK_FREQ     = clk_freq_r;
    assign frame_size   = frame_size_r;
    assign parity_type  = parity_type_r;
    assign bclk_en      = bclk_en_r;
    assign din          = din_r;
    assign tx_en        = tx_en_r;

endmodule

// File: doc/apb_uart_regs.md
# apb_uart_regs

APB3 completer that owns the UART's configuration registers, launches transmit bytes and buffers received bytes. It sits between the system APB bus and the `uart` top: it drives `uart`'s configuration, `din`, `tx_en` and `bclk_en` inputs, and consumes its `tx_done`, `rx_done`, `dout`, `error` and `BR_config_error` outputs. Everything runs on one clock.

## Interface
Parameters:
- RX_DEPTH, 4, RX FIFO depth in entries; power of 2, minimum 2.
- RST_BAUD, 115200, reset value of BAUD_TX and BAUD_RX.
- RST_CLK_FREQ, 50000000, reset value of CLK_FREQ.

Ports:
- clk  in  1  system clock; one clock for the whole block.
- rstn  in  1  reset, asynchronous, active-low.
- PSEL, PENABLE, PWRITE  in  1 each  APB3 control.
- PADDR  in  8  byte address; bits [1:0] ignored.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  tied 1.
- PSLVERR  out  1  transfer error.
- BAUD_RATE_TX, BAUD_RATE_RX, CLK_FREQ  out  32 each  UART configuration.
- frame_size  out  4  data bits per frame.
- parity_type  out  2  parity mode: 00 none, 01 odd, 10 even.
- bclk_en  out  1  baud generator enable.
- din  out  8  TX byte.
- tx_en  out  1  TX request.
- tx_done, rx_done, error, BR_config_error  in  1 each  UART status.
- dout  in  8  RX byte.

## Operation
Register map:
- 0x00 CTRL, RW: [0] bclk_en, [4:1] frame_size, [6:5] parity_type. Reset values: 0, 8, 00.
- 0x04 BAUD_TX, RW. 0x08 BAUD_RX, RW. 0x0C CLK_FREQ, RW. Reset values come from the parameters.
- 0x10 TXDATA, write-only. Writes PWDATA[7:0] to din and starts a transmit. Reads return 0.
- 0x14 RXDATA, read-only. A read pops the FIFO head and returns it in [7:0]. Writes cause PSLVERR.
- 0x18 STATUS, bit by bit:
  - [0] tx_busy, RO.
  - [1] rx_empty, RO.
  - [2] rx_full, RO.
  - [3] overrun, sticky, write-1-to-clear.
  - [4] rx_err, sticky, write-1-to-clear.
  - [5] BR_config_error, live, RO.
  - [11:8] rx_count, RO.
- Unmapped addresses: PSLVERR=1, PRDATA=0, no side effect.

TX FSM:
- IDLE: tx_en=0. A TXDATA write latches din, sets tx_en=1 and moves to BUSY.
- BUSY: tx_en held at 1. On a tx_done rising edge: tx_en=0, go to IDLE.
- A TXDATA write while in BUSY gives PSLVERR=1; din is unchanged and the write is dropped.

RX path:
- rx_done is registered; a rising edge (rx_done=1, previous=0) is a push of dout.
- If error=1 on the push cycle, set rx_err. The byte is still pushed.
- Push while full with no pop in the same cycle: byte dropped, overrun set.
- Push and pop in the same cycle when full: both succeed, count unchanged.
- Push and pop in the same cycle when empty: the pop is an error (PSLVERR=1, PRDATA=0) and the push succeeds, count becomes 1.
- RXDATA read while empty: PSLVERR=1, PRDATA=0, pointers unchanged.
- Read and write pointers are log2(RX_DEPTH) bits and wrap modulo RX_DEPTH. Count is a separate counter, 0..RX_DEPTH.
- Sticky bits set and W1C in the same cycle: set wins.

## Timing
- Zero wait states; PREADY=1 always.
- A transfer completes in the access cycle (PSEL & PENABLE).
- PRDATA and PSLVERR are combinational during the access cycle and 0 otherwise.
- Register writes, FIFO pops and W1C clears take effect at the clock edge that ends the access cycle.
- A TXDATA write in access cycle N makes tx_en=1 and tx_busy=1 from cycle N+1.
- A tx_done rising edge sampled at edge E makes tx_en=0 after E. A TXDATA write is accepted from the next access cycle.
- An rx_done rise in cycle N (sampled at the end of N) makes rx_count and rx_empty update in cycle N+1. RXDATA is readable in cycle N+1.
- Reset (asynchronous, at any time, including mid-transmit):
  - tx_en=0, din=0, FSM=IDLE, FIFO empty, sticky bits 0.
  - All config outputs take their reset values.
- Config writes while BUSY take effect immediately; software is responsible for timing them.

## Configuration
- APB_UART_RX_FIFO_EN defined: the RX FIFO has RX_DEPTH entries, as described above.
- APB_UART_RX_FIFO_EN undefined: a single holding register; RX_DEPTH is ignored.
  - rx_full = !rx_empty, rx_count is 0 or 1.
  - Overrun rules apply with depth 1.

## Test plan
- Reset, then read 0x00, 0x04, 0x0C and 0x18. Expected: 0x10, 115200, 50000000 and STATUS=0x002 (rx_empty only). PSLVERR=0 on every read.
- TX launch and busy rejection:
  - Write 0x10 with 0xA5. Expected: din=0xA5 and tx_en=1 the next cycle.
  - Write 0x10 with 0x3C while BUSY. Expected: PSLVERR=1 and din stays 0xA5.
  - Pulse tx_done. Expected: tx_en=0 the next cycle; a new write of 0x3C is accepted.
- FIFO fill and overrun (FIFO enabled): pulse rx_done 5 times with dout=0x11..0x55. Expected: STATUS rx_full=1, overrun=1, rx_count=4. RXDATA reads return 0x11, 0x22, 0x33, 0x44, then PSLVERR=1 with data 0.
- RX error flag: pulse rx_done with error=1 and dout=0x7E. Expected: STATUS[4]=1 and the byte reads back as 0x7E. Write 0x10 to 0x18. Expected: STATUS[4]=0.
- Full-FIFO collision: with the FIFO full, read RXDATA in the same cycle as an rx_done rising edge. Expected: rx_count stays 4, overrun stays 0, and the new byte is last in read order.
- Reset mid-transmit: assert rstn=0 while BUSY. Expected: tx_en=0 immediately. After release, a TXDATA write is accepted.
